systolic_drain: RTL and testbench

- Result-side counterpart of the operand streams that feed `systolictop`.
- Captures the 2x2 PE accumulator outputs c1..c4 when each output tile completes, and tags each value with its (row, col) in the mat_dim x mat_dim result matrix C.
- Buffers the tagged values in a FIFO and streams them to downstream logic over a valid/ready interface.
- Tiles are processed row-major, tile-column fastest, matching the operand sequencing order.

---
 rtl/systolic_drain.sv | 196 +++++++++++++++++++
 tb/tb_systolic_drain.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
// systolic_drain: result-side drain for a 2x2 systolic PE array.
// When a tile completes it captures the four PE accumulators c1..c4 (which
// become final on a skewed schedule), tags each with its (row, col) in the
// mat_dim x mat_dim result matrix C, and queues them in a first-word-fall-
// through FIFO streamed out over valid/ready. Tiles are walked row-major,
// tile column fastest.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   c1..c4                PE accumulators: C[2r][2c], C[2r][2c+1],
//                         C[2r+1][2c], C[2r+1][2c+1]
//   tile_done             1-cycle pulse, c1 final this cycle (T);
//                         c2/c3 final at T+1, c4 final at T+2
//   out_valid/out_ready   FIFO head handshake
//   out_data/row/col      head entry value and its C coordinates
//   overflow              sticky: a whole tile was dropped (no space)
//   seq_err               sticky: tile_done seen while a capture was busy
//   matrix_done           1-cycle pulse after the last tile's c4 push
//   checksum              (only with DRAIN_CHECKSUM_EN) running sum of
//                         popped values, cleared once a finished matrix
//                         has fully drained
//
// Optional feature macro: DRAIN_CHECKSUM_EN
module systolic_drain #(
  parameter int data_size  = 8,
  parameter int mat_dim    = 8,
  parameter int fifo_depth = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2*data_size-1:0]       c1,
  input  logic [2*data_size-1:0]       c2,
  input  logic [2*data_size-1:0]       c3,
  input  logic [2*data_size-1:0]       c4,
  input  logic                         tile_done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*data_size-1:0]       out_data,
  output logic [$clog2(mat_dim)-1:0]   out_row,
  output logic [$clog2(mat_dim)-1:0]   out_col,
  output logic                         overflow,
  output logic                         seq_err,
`ifdef DRAIN_CHECKSUM_EN
  output logic [2*data_size+$clog2(mat_dim*mat_dim)-1:0] checksum,
`endif
  output logic                         matrix_done
);

  localparam int DW = 2*data_size;
  localparam int RW = $clog2(mat_dim);
  localparam int AW = $clog2(fifo_depth);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [RW-1:0] col;
    logic [DW-1:0] val;
  } entry_t;

  typedef enum logic [1:0] {IDLE, CAP0, CAP1, CAP2} state_t;

  state_t        state, state_nxt;
  logic          acc;            // current tile admitted
  logic          admit;
  logic [DW-1:0] c3_q, c4_q;
  logic [RW-1:0] tile_r, tile_c;
  logic [RW-1:0] base_r, base_c;
  logic          last_tile;

  logic          push, pop;
  entry_t        push_e, head;
  entry_t        mem [fifo_depth];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  assign base_r    = tile_r << 1;
  assign base_c    = tile_c << 1;
  assign last_tile = (tile_r == RW'(mat_dim/2 - 1)) && (tile_c == RW'(mat_dim/2 - 1));

  assign pop       = out_valid && out_ready;

  // The whole tile is admitted up front: 4 free slots guarantees the three
  // following pushes can never hit a full FIFO, since pops only free space.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_e    = '0;
    admit     = 1'b0;
    case (state)
      IDLE: if (tile_done) begin
        state_nxt = CAP0;
        admit     = (count - CW'(pop)) <= CW'(fifo_depth - 4);
        push      = admit;
        push_e    = {base_r, base_c, c1};
      end
      CAP0: begin
        state_nxt = CAP1;
        push      = acc;
        push_e    = {base_r, base_c | RW'(1), c2};
      end
      CAP1: begin
        state_nxt = CAP2;
        push      = acc;
        push_e    = {base_r | RW'(1), base_c, c3_q};
      end
      CAP2: begin
        state_nxt = IDLE;
        push      = acc;
        push_e    = {base_r | RW'(1), base_c | RW'(1), c4_q};
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= 1'b0;
      c3_q        <= '0;
      c4_q        <= '0;
      tile_r      <= '0;
      tile_c      <= '0;
      overflow    <= 1'b0;
      seq_err     <= 1'b0;
      matrix_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      matrix_done <= 1'b0;
      if (state == IDLE && tile_done) begin
        acc <= admit;
        if (!admit) overflow <= 1'b1;
      end
      if (state != IDLE && tile_done) seq_err <= 1'b1;
      // c3 is final at T+1 but the write port is busy with c2 then.
      if (state == CAP0) c3_q <= c3;
      if (state == CAP1) c4_q <= c4;
      // Dropped tiles still walk the tile grid.
      if (state == CAP2) begin
        matrix_done <= last_tile;
        if (tile_c == RW'(mat_dim/2 - 1)) begin
          tile_c <= '0;
          tile_r <= last_tile ? '0 : tile_r + RW'(1);
        end else begin
          tile_c <= tile_c + RW'(1);
        end
      end
    end
  end

  // FIFO storage: no reset needed, validity lives in count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_e;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rptr];
  assign out_valid = (count != '0);
  // Gate with valid so the outputs read 0 when empty (incl. after reset).
  assign out_data  = out_valid ? head.val : '0;
  assign out_row   = out_valid ? head.row : '0;
  assign out_col   = out_valid ? head.col : '0;

`ifdef DRAIN_CHECKSUM_EN
  localparam int SW = 2*data_size + $clog2(mat_dim*mat_dim);
  logic md_seen;     // matrix finished, waiting for the FIFO to drain
  logic cs_clr;

  assign cs_clr = md_seen && (count == '0) && !push;

  always_ff @(posedge clk) begin
    if (reset || cs_clr) begin
      checksum <= '0;
      md_seen  <= 1'b0;
    end else begin
      if (matrix_done) md_seen  <= 1'b1;
      if (pop)         checksum <= checksum + SW'(head.val);
    end
  end
`endif

endmodule

// File: tb/tb_systolic_drain.sv
module tb_systolic_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] c1, c2, c3, c4;
  logic        tile_done, out_ready, out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_row, out_col;
  logic        overflow, seq_err, matrix_done;
`ifdef DRAIN_CHECKSUM_EN
  logic [21:0] checksum;
`endif

  int          vecs = 0;
  int          errs = 0;
  int          md_cnt = 0;
  logic [21:0] q[$];   // popped entries {row, col, data}

  systolic_drain #(.data_size(8), .mat_dim(8), .fifo_depth(16)) dut (
    .clk(clk), .reset(reset),
    .c1(c1), .c2(c2), .c3(c3), .c4(c4),
    .tile_done(tile_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .overflow(overflow), .seq_err(seq_err),
`ifdef DRAIN_CHECKSUM_EN
    .checksum(checksum),
`endif
    .matrix_done(matrix_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) q.push_back({out_row, out_col, out_data});
    if (matrix_done) md_cnt++;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; tile_done = 1'b0;
    c1 = '0; c2 = '0; c3 = '0; c4 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q.delete();
  endtask

  // Drives one tile with the PE output skew; returns at the negedge of T+3.
  task automatic drive_tile(input logic [15:0] v1, v2, v3, v4);
    @(negedge clk); tile_done = 1'b1; c1 = v1;
    @(negedge clk); tile_done = 1'b0; c2 = v2; c3 = v3;
    @(negedge clk); c4 = v4;
    @(negedge clk); c1 = '0; c2 = '0; c3 = '0; c4 = '0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if ({out_valid, overflow, seq_err, matrix_done} !== 4'b0) begin
      errs++; $display("FAIL reset_flags got %b exp 0000", {out_valid, overflow, seq_err, matrix_done});
    end
    vecs++;
    if ({out_row, out_col, out_data} !== 22'd0) begin
      errs++; $display("FAIL reset_head got %h exp 0", {out_row, out_col, out_data});
    end
  endtask

  task automatic test_single_tile();
    logic [21:0] exp [4];
    logic [21:0] got;
    exp[0] = {3'd0, 3'd0, 16'd168};
    exp[1] = {3'd0, 3'd1, 16'd140};
    exp[2] = {3'd1, 3'd0, 16'd140};
    exp[3] = {3'd1, 3'd1, 16'd120};
    do_reset();
    out_ready = 1'b1;
    drive_tile(16'd168, 16'd140, 16'd140, 16'd120);
    repeat (4) @(negedge clk);
    vecs++;
    if (q.size() !== 4) begin
      errs++; $display("FAIL single_count got %0d exp 4", q.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < q.size()) ? q[i] : 'x;
      vecs++;
      if (got !== exp[i]) begin
        errs++; $display("FAIL single_entry%0d got %h exp %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_full_matrix();
    logic [21:0] exp, got;
    int r, c, row, col;
    do_reset();
    out_ready = 1'b1;
    md_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      r = 2*(k/4); c = 2*(k%4);
      drive_tile(16'(r*16+c), 16'(r*16+c+1), 16'((r+1)*16+c), 16'((r+1)*16+c+1));
      repeat (4) @(negedge clk);
    end
    vecs++;
    if (q.size() !== 64) begin
      errs++; $display("FAIL full_count got %0d exp 64", q.size());
    end
    for (int i = 0; i < 64; i++) begin
      row = 2*((i/4)/4) + (i%4)/2;
      col = 2*((i/4)%4) + (i%2);
      exp = {3'(row), 3'(col), 16'(row*16+col)};
      got = (i < q.size()) ? q[i] : 'x;
      vecs++;
      if (got !== exp) begin
        errs++; $display("FAIL full_entry%0d got %h exp %h", i, got, exp);
      end
    end
    vecs++;
    if (md_cnt !== 1) begin
      errs++; $display("FAIL full_matrix_done got %0d pulses exp 1", md_cnt);
    end
    // Tile counter wrapped: the next tile lands at (0,0).
    q.delete();
    drive_tile(16'd7, 16'd8, 16'd9, 16'd10);
    repeat (4) @(negedge clk);
    got = (q.size() > 0) ? q[0] : 'x;
    vecs++;
    if (got !== {3'd0, 3'd0, 16'd7}) begin
      errs++; $display("FAIL full_wrap got %h exp %h", got, {3'd0, 3'd0, 16'd7});
    end
  endtask

  task automatic test_backpressure();
    logic [21:0] exp, got;
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_tile(16'(k*4+1), 16'(k*4+2), 16'(k*4+3), 16'(k*4+4));
      repeat (4) @(negedge clk);
    end
    vecs++;
    if ({out_valid, out_row, out_col, out_data} !== {1'b1, 3'd0, 3'd0, 16'd1} || q.size() != 0) begin
      errs++; $display("FAIL bp_hold got %h exp %h", {out_valid, out_row, out_col, out_data}, {1'b1, 3'd0, 3'd0, 16'd1});
    end
    drive_tile(16'd13, 16'd14, 16'd15, 16'd16);
    repeat (4) @(negedge clk);
    vecs++;
    if (overflow !== 1'b0) begin
      errs++; $display("FAIL bp_fourth_accepted got overflow=%b exp 0", overflow);
    end
    drive_tile(16'd17, 16'd18, 16'd19, 16'd20);
    repeat (4) @(negedge clk);
    vecs++;
    if (overflow !== 1'b1) begin
      errs++; $display("FAIL bp_fifth_dropped got overflow=%b exp 1", overflow);
    end
    vecs++;
    if (out_data !== 16'd1) begin
      errs++; $display("FAIL bp_head_stable got %0d exp 1", out_data);
    end
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    vecs++;
    if (q.size() !== 16) begin
      errs++; $display("FAIL bp_count got %0d exp 16", q.size());
    end
    for (int i = 0; i < 16; i++) begin
      exp = {3'((i%4)/2), 3'(2*(i/4) + (i%2)), 16'(i+1)};
      got = (i < q.size()) ? q[i] : 'x;
      vecs++;
      if (got !== exp) begin
        errs++; $display("FAIL bp_entry%0d got %h exp %h", i, got, exp);
      end
    end
  endtask

  // Follows backpressure without reset: 5 tiles consumed, next is (r=1,c=1).
  task automatic test_seq_err();
    logic [21:0] got;
    q.delete();
    @(negedge clk); tile_done = 1'b1; c1 = 16'd11;
    @(negedge clk); tile_done = 1'b0; c2 = 16'd12; c3 = 16'd13;
    @(negedge clk); tile_done = 1'b1; c4 = 16'd14;
    @(negedge clk); tile_done = 1'b0; c1 = '0; c2 = '0; c3 = '0; c4 = '0;
    repeat (6) @(negedge clk);
    vecs++;
    if (seq_err !== 1'b1) begin
      errs++; $display("FAIL seq_flag got %b exp 1", seq_err);
    end
    vecs++;
    if (q.size() !== 4) begin
      errs++; $display("FAIL seq_count got %0d exp 4", q.size());
    end
    got = (q.size() > 3) ? q[3] : 'x;
    vecs++;
    if (got !== {3'd3, 3'd3, 16'd14}) begin
      errs++; $display("FAIL seq_last_entry got %h exp %h", got, {3'd3, 3'd3, 16'd14});
    end
    drive_tile(16'd21, 16'd22, 16'd23, 16'd24);
    repeat (4) @(negedge clk);
    got = (q.size() > 4) ? q[4] : 'x;
    vecs++;
    if (got !== {3'd2, 3'd4, 16'd21}) begin
      errs++; $display("FAIL seq_next_tile got %h exp %h", got, {3'd2, 3'd4, 16'd21});
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] got;
    vecs++;
    if ({overflow, seq_err} !== 2'b11) begin
      errs++; $display("FAIL rst_pre_sticky got %b exp 11", {overflow, seq_err});
    end
    @(negedge clk); tile_done = 1'b1; c1 = 16'd99;
    @(negedge clk); tile_done = 1'b0; c2 = 16'd98; c3 = 16'd97; reset = 1'b1;
    @(negedge clk);
    vecs++;
    if ({out_valid, overflow, seq_err} !== 3'b000) begin
      errs++; $display("FAIL rst_mid got %b exp 000", {out_valid, overflow, seq_err});
    end
    reset = 1'b0; c1 = '0; c2 = '0; c3 = '0; c4 = '0;
    repeat (4) @(negedge clk);
    q.delete();
    drive_tile(16'd31, 16'd32, 16'd33, 16'd34);
    repeat (4) @(negedge clk);
    vecs++;
    if (q.size() !== 4) begin
      errs++; $display("FAIL rst_next_count got %0d exp 4", q.size());
    end
    got = (q.size() > 0) ? q[0] : 'x;
    vecs++;
    if (got !== {3'd0, 3'd0, 16'd31}) begin
      errs++; $display("FAIL rst_next_tag got %h exp %h", got, {3'd0, 3'd0, 16'd31});
    end
  endtask

`ifdef DRAIN_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive_tile(16'd1, 16'd1, 16'd1, 16'd1);
      if (k != 15) repeat (4) @(negedge clk);
    end
    // Last entry pops at T+4; FIFO empty at T+5, cleared after that cycle.
    repeat (2) @(negedge clk);
    vecs++;
    if (checksum !== 22'd64 || out_valid !== 1'b0) begin
      errs++; $display("FAIL checksum got %0d (valid %b) exp 64", checksum, out_valid);
    end
    @(negedge clk);
    vecs++;
    if (checksum !== 22'd0) begin
      errs++; $display("FAIL checksum_clear got %0d exp 0", checksum);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; tile_done = 1'b0; out_ready = 1'b0;
    c1 = '0; c2 = '0; c3 = '0; c4 = '0;
    test_reset();
    test_single_tile();
    test_full_matrix();
    test_backpressure();
    test_seq_err();
    test_reset_mid();
`ifdef DRAIN_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
